// File: rtl/ramb4_s4_s1_fifo_ctl_pkg.sv
// ramb4_s4_s1_fifo_ctl_pkg: RAM geometry constants and pointer/level types
package ramb4_s4_s1_fifo_ctl_pkg;
  localparam int DEPTH_BITS = 4096;
  localparam int NIB_AW = 10;
  localparam int BIT_AW = 12;
  localparam int LVL_W = 13;
  localparam int FULL_LIMIT = 4092;
  typedef logic [NIB_AW-1:0] nptr_t;
  typedef logic [BIT_AW-1:0] bptr_t;
  typedef logic [LVL_W-1:0] lvl_t;
endpackage

// File: rtl/ramb4_s4_s1_fifo_ctl_ram.sv
// ramb4_s4_s1_fifo_ctl_ram: RAMB4_S1_S4 model, 4096x1 read/write port A and 1024x4 write port B
module ramb4_s4_s1_fifo_ctl_ram
  import ramb4_s4_s1_fifo_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       ena_i,
  input  logic       wea_i,
  input  logic       rsta_i,
  input  bptr_t      addra_i,
  input  logic       dia_i,
  output logic       doa_o,
  input  logic       enb_i,
  input  logic       web_i,
  input  nptr_t      addrb_i,
  input  logic [3:0] dib_i
);
  logic mem [DEPTH_BITS];
  always_ff @(posedge clk) begin
    if (ena_i) begin
      if (wea_i) mem[addra_i] <= dia_i;
      doa_o <= rsta_i ? 1'b0 : (wea_i ? dia_i : mem[addra_i]);
    end
    // nibble N occupies bit addresses 4N..4N+3, DIB[k] at 4N+k
    if (enb_i && web_i)
      for (int k = 0; k < 4; k++) mem[{addrb_i, 2'(k)}] <= dib_i[k];
  end
endmodule

// File: rtl/ramb4_s4_s1_fifo_ctl.sv
// ramb4_s4_s1_fifo_ctl: nibble-in / bit-out FIFO controller around a 4096-bit dual-port RAM
module ramb4_s4_s1_fifo_ctl
  import ramb4_s4_s1_fifo_ctl_pkg::*;
#(
  parameter int AFULL_BITS = 3584,
  parameter int AEMPTY_BITS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             PUSH,
  input  logic [3:0]       DIN,
  output logic             FULL,
  output logic             ALMOST_FULL,
  input  logic             POP,
  output logic             DOUT,
  output logic             DOUT_VALID,
  output logic             EMPTY,
  output logic             ALMOST_EMPTY,
  output logic [LVL_W-1:0] LEVEL,
  output logic             OVFL,
  output logic             UDFL
);
  nptr_t wptr_q, wptr_d;
  bptr_t rptr_q, rptr_d;
  lvl_t lvl_q, lvl_d;
  logic ovfl_q, ovfl_d, udfl_q, udfl_d, dv_q;
  logic push_ok, pop_ok;
  always_comb begin
    FULL = lvl_q > lvl_t'(FULL_LIMIT);
    ALMOST_FULL = lvl_q >= lvl_t'(AFULL_BITS);
    EMPTY = lvl_q == '0;
    ALMOST_EMPTY = lvl_q <= lvl_t'(AEMPTY_BITS);
    // flush and reset swallow any push/pop in the same cycle, including the RAM strobes
    push_ok = PUSH & ~FULL & ~FLUSH & ~RST;
    pop_ok = POP & ~EMPTY & ~FLUSH & ~RST;
    wptr_d = FLUSH ? '0 : wptr_q + nptr_t'(push_ok);
    rptr_d = FLUSH ? '0 : rptr_q + bptr_t'(pop_ok);
    lvl_d = FLUSH ? '0 : lvl_q + (push_ok ? lvl_t'(4) : '0) - lvl_t'(pop_ok);
    ovfl_d = ~FLUSH & (ovfl_q | (PUSH & FULL));
    udfl_d = ~FLUSH & (udfl_q | (POP & EMPTY));
    LEVEL = lvl_q;
    OVFL = ovfl_q;
    UDFL = udfl_q;
    DOUT_VALID = dv_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q <= '0;
      ovfl_q <= 1'b0;
      udfl_q <= 1'b0;
      dv_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lvl_q <= lvl_d;
      ovfl_q <= ovfl_d;
      udfl_q <= udfl_d;
      dv_q <= pop_ok;
    end
  end
  ramb4_s4_s1_fifo_ctl_ram u_ram (
    .clk     (CLK),
    .ena_i   (pop_ok),
    .wea_i   (1'b0),
    .rsta_i  (1'b0),
    .addra_i (rptr_q),
    .dia_i   (1'b0),
    .doa_o   (DOUT),
    .enb_i   (push_ok),
    .web_i   (push_ok),
    .addrb_i (wptr_q),
    .dib_i   (DIN)
  );
endmodule
